bcd_counter_chain: RTL and testbench

Parametrised multi-digit BCD event counter and the successor to the single-digit bcdCount. It chains NUM_DIGITS decade stages with an internal ripple-carry. It adds count enable, synchronous clear, a gate-window snapshot register and sticky overflow. It sits in the frequency-counter datapath: input events drive en, and the gate timer drives latch/clr.

---
 rtl/bcd_counter_chain.sv | 145 ++++++++++++++
 tb/tb_bcd_counter_chain.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_chain.sv
// bcd_counter_chain: multi-digit BCD event counter with ripple-carry between
// decades, count enable, synchronous clear, a snapshot register loaded by
// latch, and a sticky overflow flag.
// Optional feature: define BCD_COUNTER_UPDOWN_EN to add the dn input
// (BCD down-count with borrow propagation).
module bcd_counter_chain #(
  parameter  int NUM_DIGITS = 4,
  localparam int W          = 4 * NUM_DIGITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         latch,
`ifdef BCD_COUNTER_UPDOWN_EN
  input  logic         dn,
`endif
  output logic [W-1:0] count,
  output logic         carry,
  output logic         overflow,
  output logic [W-1:0] count_q,
  output logic         ovf_q,
  output logic         q_valid
);

  // Count direction: 1 = decrement. It is tied low in the up-only build.
  logic down_w;
`ifdef BCD_COUNTER_UPDOWN_EN
  assign down_w = dn;
`else
  assign down_w = 1'b0;
`endif

  // Live state and snapshot state
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         ovf_live_q;
  logic         ovf_live_d;
  logic [W-1:0] snap_cnt_q;
  logic         snap_ovf_q;
  logic         q_valid_q;

  // Per-digit classification:
  // - is_term marks the digit that rolls over on an up-count (>= 9, so that
  //   the illegal codes 10..15 also roll over).
  // - is_nine and is_zero are strict and drive the external carry.
  logic [NUM_DIGITS-1:0] is_term;
  logic [NUM_DIGITS-1:0] is_nine;
  logic [NUM_DIGITS-1:0] is_zero;

  // chain[k] = every digit below k is at its rollover value in the
  // current direction. chain[0] is always 1.
  logic [NUM_DIGITS:0]   chain;

  logic step;
  logic wrap;

  assign step = en & ~clr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] dig;
      logic [3:0] nxt;

      assign dig         = cnt_q[4*gi +: 4];
      assign is_term[gi] = (dig >= 4'd9);
      assign is_nine[gi] = (dig == 4'd9);
      assign is_zero[gi] = (dig == 4'd0);

      // Next value of this decade. An illegal code snaps back to a legal
      // one on the next step in either direction.
      always_comb begin
        nxt = dig;
        if (clr) begin
          nxt = 4'd0;
        end else if (en && chain[gi]) begin
          if (down_w) begin
            if (is_zero[gi])       nxt = 4'd9;
            else if (dig > 4'd9)   nxt = 4'd9;
            else                   nxt = dig - 4'd1;
          end else begin
            if (is_term[gi])       nxt = 4'd0;
            else                   nxt = dig + 4'd1;
          end
        end
      end

      assign cnt_d[4*gi +: 4] = nxt;
    end
  endgenerate

  // Ripple-carry / ripple-borrow chain between the decades
  always_comb begin
    chain    = '0;
    chain[0] = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      chain[k+1] = chain[k] & (down_w ? is_zero[k] : is_term[k]);
    end
  end

  // A full-range wrap happens when the step ripples through every digit
  assign wrap = step & chain[NUM_DIGITS];

  // Sticky overflow. Clear has priority over a simultaneous wrap.
  always_comb begin
    ovf_live_d = ovf_live_q;
    if (clr)       ovf_live_d = 1'b0;
    else if (wrap) ovf_live_d = 1'b1;
  end

  // Live counter and overflow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      ovf_live_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ovf_live_q <= ovf_live_d;
    end
  end

  // Snapshot of the pre-edge count and overflow. q_valid follows latch by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_cnt_q <= '0;
      snap_ovf_q <= 1'b0;
      q_valid_q  <= 1'b0;
    end else begin
      q_valid_q <= latch;
      if (latch) begin
        snap_cnt_q <= cnt_q;
        snap_ovf_q <= ovf_live_q;
      end
    end
  end

  assign count    = cnt_q;
  assign overflow = ovf_live_q;
  assign count_q  = snap_cnt_q;
  assign ovf_q    = snap_ovf_q;
  assign q_valid  = q_valid_q;
  assign carry    = en & (down_w ? (&is_zero) : (&is_nine));

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Testbench for bcd_counter_chain (NUM_DIGITS = 4).
// The directed stimulus pushes each expected snapshot into a queue.
// A separate monitor pops from the queue and compares whenever q_valid is high.
module tb_bcd_counter_chain;

  localparam int ND = 4;
  localparam int WW = 4 * ND;

  logic          clk;
  logic          reset;
  logic          en;
  logic          clr;
  logic          latch;
  logic          dn;
  logic [WW-1:0] count;
  logic          carry;
  logic          overflow;
  logic [WW-1:0] snap;
  logic          snap_ovf;
  logic          q_valid;

  int n_checks = 0;
  int n_fail   = 0;
  bit carry_seen;

  typedef struct packed {
    logic [WW-1:0] cnt;
    logic          ovf;
  } snap_t;

  snap_t exp_q[$];

  bcd_counter_chain #(.NUM_DIGITS(ND)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .latch    (latch),
`ifdef BCD_COUNTER_UPDOWN_EN
    .dn       (dn),
`endif
    .count    (count),
    .carry    (carry),
    .overflow (overflow),
    .count_q  (snap),
    .ovf_q    (snap_ovf),
    .q_valid  (q_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each snapshot pulse must match the oldest pending expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL snapshot: unexpected q_valid, count_q=%0h ovf_q=%0b", snap, snap_ovf);
        end else begin
          snap_t e;
          e = exp_q.pop_front();
          n_checks++;
          if (snap !== e.cnt || snap_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL snapshot: got count_q=%0h ovf_q=%0b expected count_q=%0h ovf_q=%0b",
                     snap, snap_ovf, e.cnt, e.ovf);
          end else begin
            $display("ok   snapshot: count_q=%0h ovf_q=%0b", snap, snap_ovf);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; latch = 1'b0; dn = 1'b0;
    carry_seen = 1'b0;

    // Hold reset low for 3 cycles, then check the reset state
    repeat (3) tick();
    check("reset_count",    count,    0);
    check("reset_overflow", overflow, 0);
    check("reset_count_q",  snap,     0);
    check("reset_ovf_q",    snap_ovf, 0);
    check("reset_q_valid",  q_valid,  0);

    // Count 1234 events; carry must stay low throughout
    reset = 1'b1;
    en    = 1'b1;
    repeat (1234) begin
      if (carry) carry_seen = 1'b1;
      tick();
    end
    check("count_1234",      count,      16'h1234);
    check("ovf_after_1234",  overflow,   0);
    check("carry_never_high", carry_seen, 0);

    // Snapshot with en low
    en = 1'b0; latch = 1'b1;
    exp_q.push_back('{cnt: 16'h1234, ovf: 1'b0});
    tick();
    latch = 1'b0;
    check("count_hold", count, 16'h1234);

    // Count up to 9999, then wrap
    en = 1'b1;
    repeat (8765) tick();
    check("count_9999",    count,    16'h9999);
    check("carry_at_9999", carry,    1);
    check("ovf_pre_wrap",  overflow, 0);
    tick();
    check("count_wrap",    count,    16'h0000);
    check("ovf_wrap",      overflow, 1);
    check("carry_post",    carry,    0);
    en = 1'b0;
    repeat (2) tick();
    check("ovf_sticky",    overflow, 1);
    en = 1'b1;
    repeat (3) tick();
    check("count_3",       count,    16'h0003);
    check("ovf_sticky2",   overflow, 1);

    // Snapshot while counting: the same-cycle increment is excluded
    latch = 1'b1;
    exp_q.push_back('{cnt: 16'h0003, ovf: 1'b1});
    tick();
    check("count_4", count, 16'h0004);
    // Back-to-back latch: q_valid stays high
    exp_q.push_back('{cnt: 16'h0004, ovf: 1'b1});
    tick();
    check("q_valid_b2b", q_valid, 1);
    latch = 1'b0;
    tick();
    check("q_valid_drop", q_valid, 0);
    check("count_6",      count,   16'h0006);

    // Clear affects only the live side
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_count",    count,    16'h0000);
    check("clr_overflow", overflow, 0);
    check("clr_keep_q",   snap,     16'h0004);
    check("clr_keep_ovf", snap_ovf, 1);

    // Gate boundary: latch+clr+en together
    en = 1'b1;
    repeat (500) tick();
    check("count_0500", count, 16'h0500);
    latch = 1'b1; clr = 1'b1;
    exp_q.push_back('{cnt: 16'h0500, ovf: 1'b0});
    tick();
    latch = 1'b0; clr = 1'b0; en = 1'b0;
    check("gate_count", count, 16'h0000);
    tick();
    check("gate_pulse_end", q_valid, 0);

    // Clear has priority over enable
    en = 1'b1; clr = 1'b1;
    repeat (5) tick();
    check("clr_prio", count, 16'h0000);
    clr = 1'b0;
    repeat (3) tick();
    check("count_0003", count, 16'h0003);

    // Asynchronous reset in mid-cycle
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1;
    repeat (42) tick();
    check("count_0042", count, 16'h0042);
    #3 reset = 1'b0;
    #1;
    check("async_count",    count,    0);
    check("async_overflow", overflow, 0);
    check("async_count_q",  snap,     0);
    check("async_ovf_q",    snap_ovf, 0);
    check("async_q_valid",  q_valid,  0);
    tick();
    reset = 1'b1;
    tick();
    check("resume_0001", count, 16'h0001);

`ifdef BCD_COUNTER_UPDOWN_EN
    // Down-count from zero wraps to 9999
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; dn = 1'b1;
    #1;
    check("dn_carry", carry, 1);
    tick();
    check("dn_wrap",     count,    16'h9999);
    check("dn_overflow", overflow, 1);
    dn = 1'b0;
    tick();
    check("up_from_9999", count, 16'h0000);
`endif

    // Let the scoreboard drain; every expected snapshot must have appeared
    en = 1'b0;
    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
